// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - shared SUBLEQ constants, PC op enum and request priority encoder
//
// Purpose: definitions shared by the program-counter unit and the sequencer.
//   SUBLEQ_WORD_SIZE : default address/PC width in bits
//   SUBLEQ_STEP      : words per SUBLEQ instruction (PC increment)
//   pc_op_t          : PC operation selected for one edge
//   pc_op_decode     : picks one op from the request lines, ret > call > branch > inc
package subleq_pkg;

  localparam int SUBLEQ_WORD_SIZE = 16;
  localparam int SUBLEQ_STEP      = 3;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_CALL,
    PC_RET
  } pc_op_t;

  // Lower-priority requests are simply dropped, never queued.
  function automatic pc_op_t pc_op_decode(input logic inc, input logic branch,
                                          input logic call, input logic ret);
    pc_op_t op;
    op = PC_HOLD;
    if (ret)         op = PC_RET;
    else if (call)   op = PC_CALL;
    else if (branch) op = PC_BRANCH;
    else if (inc)    op = PC_INC;
    return op;
  endfunction

endpackage

// File: rtl/subleq_ras.sv
// rtl/subleq_ras.sv - return-address stack (LIFO) for the SUBLEQ PC unit
//
// Purpose: DEPTH x WIDTH last-in first-out store of return addresses.
// Ports:
//   clk       in  rising-edge clock
//   areset    in  synchronous active-high reset, empties the stack
//   push      in  write push_data on top (ignored when full)
//   pop       in  discard the top entry (ignored when empty)
//   push_data in  WIDTH  value to push
//   top       out WIDTH  current top entry ('0 when empty)
//   count     out occupied entries
//   full      out count == DEPTH
//   empty     out count == 0
// Entry contents are not reset; only the occupancy count is.
module subleq_ras #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_wr_idx  = IDX_W'(r_count);
  assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
  assign top       = empty ? '0 : r_mem[w_top_idx];

  // Pop wins if both are requested; the top unit never asks for both.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !pop && !full;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_count <= '0;
    end else if (w_do_pop) begin
      r_count <= r_count - CNT_W'(1);
    end else if (w_do_push) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset && w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/subleq_pc_unit.sv
// rtl/subleq_pc_unit.sv - SUBLEQ program counter with return-address stack and halt detect
//
// Purpose: holds the fetch address; increments by STEP, branches, calls and
// returns through a hardware RAS; keeps sticky stack-error flags.
// Optional macro SUBLEQ_PC_HALT_EN: a branch/call to the current PC sets
// halted and freezes the unit until reset. Without it halted is tied 0.
// Ports:
//   clk       in  rising-edge clock
//   areset    in  synchronous active-high reset
//   en        in  update enable (0 holds all state, flags included)
//   inc       in  pc <- pc + STEP
//   branch    in  pc <- addr
//   call      in  push pc + STEP, pc <- addr
//   ret       in  pc <- RAS top, pop
//   addr      in  WORD_SIZE  branch/call target
//   pc_out    out WORD_SIZE  registered PC
//   ras_count out occupied RAS entries
//   ras_ovf   out sticky: call with RAS full
//   ras_unf   out sticky: ret with RAS empty
//   halted    out sticky halt flag
module subleq_pc_unit
  import subleq_pkg::*;
#(
  parameter int                   WORD_SIZE  = SUBLEQ_WORD_SIZE,
  parameter int                   STEP       = SUBLEQ_STEP,
  parameter int                   RAS_DEPTH  = 4,
  parameter logic [WORD_SIZE-1:0] RESET_ADDR = '0
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic                             en,
  input  logic                             inc,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic [WORD_SIZE-1:0]             addr,
  output logic [WORD_SIZE-1:0]             pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_ovf,
  output logic                             ras_unf,
  output logic                             halted
);

  logic [WORD_SIZE-1:0] r_pc;
  logic                 r_ovf;
  logic                 r_unf;
  logic [WORD_SIZE-1:0] w_pc_next_seq;
  logic [WORD_SIZE-1:0] w_ras_top;
  logic                 w_ras_full;
  logic                 w_ras_empty;
  logic                 w_run;
  pc_op_t               w_op;

  assign w_op          = pc_op_decode(inc, branch, call, ret);
  assign w_pc_next_seq = r_pc + WORD_SIZE'(STEP);

`ifdef SUBLEQ_PC_HALT_EN
  logic r_halted;
  logic w_self;

  // Once halted, the unit behaves as if en were permanently low.
  assign w_run  = en && !r_halted;
  assign w_self = ((w_op == PC_BRANCH) || (w_op == PC_CALL)) && (addr == r_pc);
  assign halted = r_halted;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_halted <= 1'b0;
    end else if (w_run && w_self) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign w_run  = en;
  assign halted = 1'b0;
`endif

  subleq_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WORD_SIZE)
  ) u_ras (
    .clk       (clk),
    .areset    (areset),
    .push      (w_run && (w_op == PC_CALL)),
    .pop       (w_run && (w_op == PC_RET)),
    .push_data (w_pc_next_seq),
    .top       (w_ras_top),
    .count     (ras_count),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      r_pc  <= RESET_ADDR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_run) begin
      case (w_op)
        PC_RET: begin
          if (w_ras_empty) r_unf <= 1'b1;
          else             r_pc  <= w_ras_top;
        end
        PC_CALL: begin
          // A dropped push still takes the jump.
          if (w_ras_full) r_ovf <= 1'b1;
          r_pc <= addr;
        end
        PC_BRANCH: r_pc <= addr;
        PC_INC:    r_pc <= w_pc_next_seq;
        default:   r_pc <= r_pc;
      endcase
    end
  end

  assign pc_out  = r_pc;
  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

endmodule

// File: tb/tb_subleq_pc_unit.sv
// tb/tb_subleq_pc_unit.sv - scoreboard bench for subleq_pc_unit with a queue-based reference model
module tb_subleq_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        en = 1'b0;
  logic        inc = 1'b0;
  logic        branch = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] pc_out;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;
  logic        halted;

  subleq_pc_unit #(
    .WORD_SIZE  (16),
    .STEP       (3),
    .RAS_DEPTH  (DEPTH),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .en        (en),
    .inc       (inc),
    .branch    (branch),
    .call      (call),
    .ret       (ret),
    .addr      (addr),
    .pc_out    (pc_out),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    int          cnt;
    bit          ovf;
    bit          unf;
    bit          hlt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: the stack is a plain queue of return addresses.
  logic [15:0] m_pc = '0;
  logic [15:0] m_ras[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;
  bit          m_hlt = 0;

  task automatic model_step(input bit rst, input bit e, input bit i, input bit b,
                            input bit c, input bit r, input logic [15:0] a);
    bit self_hit;
    self_hit = 0;
    if (rst) begin
      m_pc = 16'h0000;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
      m_hlt = 0;
    end else if (e && !m_hlt) begin
`ifdef SUBLEQ_PC_HALT_EN
      self_hit = (a == m_pc);
`endif
      if (r) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else                  m_unf = 1;
      end else if (c) begin
        if (self_hit) m_hlt = 1;
        if (m_ras.size() < DEPTH) m_ras.push_back(m_pc + 16'd3);
        else                      m_ovf = 1;
        m_pc = a;
      end else if (b) begin
        if (self_hit) m_hlt = 1;
        m_pc = a;
      end else if (i) begin
        m_pc = m_pc + 16'd3;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit e, input bit i, input bit b,
                     input bit c, input bit r, input logic [15:0] a);
    exp_t x;
    @(negedge clk);
    areset = rst; en = e; inc = i; branch = b; call = c; ret = r; addr = a;
    model_step(rst, e, i, b, c, r, a);
    x.pc  = m_pc;
    x.cnt = m_ras.size();
    x.ovf = m_ovf;
    x.unf = m_unf;
    x.hlt = m_hlt;
    sb.push_back(x);
  endtask

  task automatic op_rst();                   cyc(1, 0, 0, 0, 0, 0, 16'h0); endtask
  task automatic op_inc();                   cyc(0, 1, 1, 0, 0, 0, 16'h0); endtask
  task automatic op_br(input logic [15:0] a);   cyc(0, 1, 0, 1, 0, 0, a); endtask
  task automatic op_call(input logic [15:0] a); cyc(0, 1, 0, 0, 1, 0, a); endtask
  task automatic op_ret();                   cyc(0, 1, 0, 0, 0, 1, 16'h0); endtask

  // Monitor: one registered result is presented after every active edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_vec++;
        if (pc_out !== x.pc) begin
          n_err++;
          $display("FAIL pc_out vec %0d: got %h expected %h", n_vec, pc_out, x.pc);
        end
        if (ras_count !== 3'(x.cnt)) begin
          n_err++;
          $display("FAIL ras_count vec %0d: got %0d expected %0d", n_vec, ras_count, x.cnt);
        end
        if (ras_ovf !== x.ovf) begin
          n_err++;
          $display("FAIL ras_ovf vec %0d: got %b expected %b", n_vec, ras_ovf, x.ovf);
        end
        if (ras_unf !== x.unf) begin
          n_err++;
          $display("FAIL ras_unf vec %0d: got %b expected %b", n_vec, ras_unf, x.unf);
        end
        if (halted !== x.hlt) begin
          n_err++;
          $display("FAIL halted vec %0d: got %b expected %b", n_vec, halted, x.hlt);
        end
      end
    end
  end

  initial begin
    int budget;
    logic [15:0] a;

    // Reset and increment
    op_rst();
    repeat (4) op_inc();

    // Wrap-around
    op_br(16'hFFFE);
    op_inc();

    // Priority: branch over inc, then ret over call with an empty RAS
    op_rst();
    cyc(0, 1, 1, 1, 0, 0, 16'h0100);
    cyc(0, 1, 0, 0, 1, 1, 16'h0200);

    // Nested calls and returns, with en=0 masking in between
    op_rst();
    op_br(16'h0010);
    op_call(16'h0100);
    op_call(16'h0200);
    cyc(0, 0, 1, 1, 1, 1, 16'h0300);
    op_ret();
    op_ret();
    op_call(16'h0400);
    op_ret();

    // Overflow: five calls into a 4-deep stack, then unwind
    op_rst();
    op_call(16'h0010);
    op_call(16'h0020);
    op_call(16'h0030);
    op_call(16'h0040);
    op_call(16'h0050);
    repeat (4) op_ret();
    op_ret();

    // Reset with a non-empty stack
    op_call(16'h0123);
    op_call(16'h0456);
    op_rst();
    op_ret();

    // Self-branch: halts in the halt build, ordinary branch otherwise
    op_rst();
    op_br(16'h0040);
    op_br(16'h0040);
    op_inc();
    op_br(16'h0999);
    op_call(16'h0777);
    op_ret();
    op_rst();
    op_inc();

    // Randomized traffic, biased towards self-branches and stack activity
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) a = m_pc;
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 255));
      else a = 16'($urandom);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), a);
    end

    @(negedge clk);
    en = 1'b0; inc = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
